// File: rtl/add_1p_acc.sv
// add_1p_acc: integrate-and-dump accumulator for the add_1p sum stream.
// Sums N accepted samples into a widened accumulator and hands the block
// total downstream through a one-entry valid/ready output register.
module add_1p_acc #(
    parameter int unsigned WIDTH  = 15,
    parameter int unsigned N      = 16,
    parameter int unsigned CNTW   = 4,
    parameter int unsigned ACCW   = 19,
    parameter int unsigned SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACCW-1:0]  dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  fill
);

    localparam int unsigned EXTW = ACCW - WIDTH;

    logic [ACCW-1:0] r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [ACCW-1:0] r_dout;
    logic            r_out_valid;

    logic            w_sign;
    logic [ACCW-1:0] w_ext;
    logic [ACCW-1:0] w_sum;
    logic            w_last;
    logic            w_ready;
    logic            w_accept;

    // Sign- or zero-extend the incoming word to accumulator width.
    assign w_sign   = (SIGNED != 0) ? din[WIDTH-1] : 1'b0;
    assign w_ext    = {{EXTW{w_sign}}, din};
    assign w_sum    = r_acc + w_ext;
    assign w_last   = (r_cnt == CNTW'(N - 1));

    // Only the closing sample stalls, and only while an unconsumed result
    // would otherwise be overwritten; clr refuses input outright.
    assign w_ready  = ~clr & ~(w_last & r_out_valid & ~out_ready);
    assign w_accept = in_valid & w_ready;

    assign in_ready  = w_ready;
    assign dout      = r_dout;
    assign out_valid = r_out_valid;
    assign fill      = r_cnt;

    // Running block sum and sample counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    // Output register: completion loads a new total (even while the old
    // one is being consumed), otherwise a handshake empties the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            r_dout      <= w_sum;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_1p_acc.sv
// Scoreboard bench for add_1p_acc: directed scenarios plus randomized gapped
// traffic, checked against a sample-list reference model.
module tb_add_1p_acc;

    localparam int unsigned WIDTH = 15;
    localparam int unsigned N     = 16;
    localparam int unsigned CNTW  = 4;
    localparam int unsigned ACCW  = 19;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             clr;
    logic [ACCW-1:0]  dout;
    logic             out_valid;
    logic             out_ready;
    logic [CNTW-1:0]  fill;

    int vectors = 0;
    int errors  = 0;

    logic [ACCW-1:0] exp_q[$];
    longint          blk[$];
    bit              pend  = 1'b0;
    bit              m_acc = 1'b0;
    int              blocks = 0;

    add_1p_acc #(.WIDTH(WIDTH), .N(N), .CNTW(CNTW), .ACCW(ACCW), .SIGNED(1)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .in_valid(in_valid),
        .in_ready(in_ready), .clr(clr), .dout(dout), .out_valid(out_valid),
        .out_ready(out_ready), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [WIDTH-1:0] d);
        return d[WIDTH-1] ? longint'(d) - 64'sd32768 : longint'(d);
    endfunction

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        din       = d;
        out_ready = r;
        clr       = c;
        #1;
    endtask

    // Reference model: keeps the block's samples as integers, predicts the
    // handshake, and queues each block total when N samples are collected.
    initial begin
        bit     exp_rdy;
        bit     done;
        longint s;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                blk.delete();
                exp_q.delete();
                pend  = 1'b0;
                m_acc = 1'b0;
            end else begin
                exp_rdy = !clr && !((blk.size() == N - 1) && pend && !out_ready);
                chk("in_ready", longint'(in_ready), longint'(exp_rdy));
                chk("fill", longint'(fill), longint'(blk.size()));
                chk("out_valid", longint'(out_valid), longint'(pend));
                m_acc = in_valid && exp_rdy;
                done  = 1'b0;
                if (clr) begin
                    blk.delete();
                end else if (m_acc) begin
                    blk.push_back(sx(din));
                    if (blk.size() == N) begin
                        s = 0;
                        foreach (blk[k]) s += blk[k];
                        exp_q.push_back(ACCW'(s));
                        blk.delete();
                        blocks++;
                        done = 1'b1;
                    end
                end
                if (done) pend = 1'b1;
                else if (out_ready) pend = 1'b0;
            end
        end
    end

    // Monitor: every consumed result must match the oldest queued total.
    initial begin
        logic [ACCW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("dout_unexpected", longint'(dout), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", longint'(dout), longint'(e));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_dout", longint'(dout), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_fill", longint'(fill), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_in_ready", longint'(in_ready), 1);
        chk("post_rst_fill", longint'(fill), 0);
    endtask

    // Hard stop if anything stalls the stimulus.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACCW-1:0]  ext_c[3];
        logic [WIDTH-1:0] ext_v[3];
        logic             v, r, c;
        logic [WIDTH-1:0] d;
        int               target;
        int               ncyc;

        ext_v[0] = 15'h7FFF; ext_c[0] = 19'h7FFF0;
        ext_v[1] = 15'h3FFF; ext_c[1] = 19'h3FFF0;
        ext_v[2] = 15'h4000; ext_c[2] = 19'h40000;

        reset_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("init_dout", longint'(dout), 0);
        chk("init_out_valid", longint'(out_valid), 0);
        chk("init_fill", longint'(fill), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("init_in_ready", longint'(in_ready), 1);

        // Continuous ones, three back-to-back blocks.
        for (int i = 0; i <= 48; i++) begin
            cyc(i < 48, 15'd1, 1'b1, 1'b0);
            if (i > 0 && (i % 16) == 0) begin
                chk("ones_valid", longint'(out_valid), 1);
                chk("ones_dout", longint'(dout), 16);
            end else if (i == 17) begin
                chk("ones_gap_valid", longint'(out_valid), 0);
            end
        end

        // Signed extremes.
        for (int k = 0; k < 3; k++) begin
            repeat (16) cyc(1'b1, ext_v[k], 1'b1, 1'b0);
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("ext_valid", longint'(out_valid), 1);
            chk("ext_dout", longint'(dout), longint'(ext_c[k]));
        end

        // Backpressure: only the closing sample stalls.
        repeat (16) cyc(1'b1, 15'd2, 1'b1, 1'b0);
        repeat (15) cyc(1'b1, 15'd3, 1'b0, 1'b0);
        repeat (3) begin
            cyc(1'b1, 15'd3, 1'b0, 1'b0);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_fill", longint'(fill), 15);
            chk("bp_dout_hold", longint'(dout), 32);
        end
        cyc(1'b1, 15'd3, 1'b1, 1'b0);
        chk("bp_release_ready", longint'(in_ready), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_swap_valid", longint'(out_valid), 1);
        chk("bp_swap_dout", longint'(dout), 48);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_drain_valid", longint'(out_valid), 0);

        // Clear with a pending result and a refused sample.
        repeat (16) cyc(1'b1, 15'd1, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 15'd1, 1'b0, 1'b0);
        cyc(1'b1, 15'd7, 1'b0, 1'b1);
        chk("clr_in_ready", longint'(in_ready), 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("clr_fill", longint'(fill), 0);
        chk("clr_pending_valid", longint'(out_valid), 1);
        chk("clr_pending_dout", longint'(dout), 16);
        repeat (16) cyc(1'b1, 15'd1, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("clr_next_valid", longint'(out_valid), 1);
        chk("clr_next_dout", longint'(dout), 16);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-block with a result pending.
        repeat (19) cyc(1'b1, 15'd1, 1'b0, 1'b0);
        do_reset();

        // Randomized gapped traffic with random backpressure.
        target = blocks + 1000;
        ncyc   = 0;
        while (blocks < target && ncyc < 70000) begin
            if (in_valid && !m_acc && !clr) begin
                v = 1'b1;
                d = din;
            end else begin
                v = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       d = 15'h7FFF;
                    1:       d = 15'h4000;
                    2:       d = 15'h3FFF;
                    default: d = 15'($urandom);
                endcase
            end
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 199) == 0);
            cyc(v, d, r, c);
            ncyc++;
        end
        chk("random_blocks_done", longint'(blocks >= target), 1);

        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
